// File: rtl/fmap_pingpong_buffer.sv
// Ping-pong feature-map buffer between two conv layers.
//
// Captures one WIDTH x WIDTH frame of CHANNELS-wide pixel vectors from the upstream
// valid stream into one of two banks, then replays it in raster order through a
// registered ready/valid output stage. Capture of the next frame proceeds into the
// other bank while the current one is replayed.
//
// Ports:
//   clk        - clock, rising edge
//   rst        - asynchronous active-high reset
//   i_data     - upstream pixel vector (DATA_WIDTH*CHANNELS bits)
//   i_valid    - i_data valid this cycle
//   i_ready    - buffer can accept a beat this cycle (combinational)
//   o_data     - replayed pixel vector (registered)
//   o_valid    - o_data valid (registered)
//   o_ready    - downstream accepts o_data
//   o_last     - o_data is the final beat of its frame (registered)
//   frames_out - number of frames fully accepted downstream, wraps
//   overflow   - sticky: a beat was offered while the buffer could not take it
module fmap_pingpong_buffer #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned CHANNELS   = 32,
  parameter int unsigned WIDTH      = 7,
  parameter int unsigned CNT_WIDTH  = 16,
  localparam int unsigned BW        = DATA_WIDTH * CHANNELS,
  localparam int unsigned DEPTH     = WIDTH * WIDTH,
  localparam int unsigned AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [BW-1:0]        i_data,
  input  logic                 i_valid,
  output logic                 i_ready,
  output logic [BW-1:0]        o_data,
  output logic                 o_valid,
  input  logic                 o_ready,
  output logic                 o_last,
  output logic [CNT_WIDTH-1:0] frames_out,
  output logic                 overflow
);

  localparam logic [AW-1:0] LastAddr = AW'(DEPTH - 1);

  // Frame storage; deliberately not reset.
  logic [BW-1:0] mem [2][DEPTH];

  logic [1:0]    full_q, full_d;
  logic          wbank_q;
  logic [AW-1:0] waddr_q;
  logic          rbank_q;
  logic [AW-1:0] raddr_q;
  logic          issued_done_q;  // every beat of the current read bank is already issued

  logic accept, wr_last, advance, load, rd_last, frame_release;

  assign i_ready       = ~full_q[wbank_q];
  assign accept        = i_valid & i_ready;
  assign wr_last       = accept & (waddr_q == LastAddr);
  assign advance       = ~o_valid | o_ready;
  assign load          = advance & full_q[rbank_q] & ~issued_done_q;
  assign rd_last       = (raddr_q == LastAddr);
  assign frame_release = o_valid & o_ready & o_last;

  // Set and clear always target different banks: a bank is set only while empty
  // and cleared only while full.
  always_comb begin
    full_d = full_q;
    if (wr_last)       full_d[wbank_q] = 1'b1;
    if (frame_release) full_d[rbank_q] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (accept) mem[wbank_q][waddr_q] <= i_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      full_q        <= '0;
      wbank_q       <= 1'b0;
      waddr_q       <= '0;
      rbank_q       <= 1'b0;
      raddr_q       <= '0;
      issued_done_q <= 1'b0;
      o_data        <= '0;
      o_valid       <= 1'b0;
      o_last        <= 1'b0;
      frames_out    <= '0;
      overflow      <= 1'b0;
    end else begin
      full_q <= full_d;

      // Write side
      if (accept) begin
        waddr_q <= wr_last ? '0 : waddr_q + AW'(1);
        if (wr_last) wbank_q <= ~wbank_q;
      end
      if (i_valid && !i_ready) overflow <= 1'b1;

      // Read side output register stage
      if (load) begin
        o_data  <= mem[rbank_q][raddr_q];
        o_valid <= 1'b1;
        o_last  <= rd_last;
        raddr_q <= rd_last ? '0 : raddr_q + AW'(1);
        if (rd_last) issued_done_q <= 1'b1;
      end else if (advance) begin
        o_valid <= 1'b0;
        o_last  <= 1'b0;
      end

      // issued_done is set during a release, so load is false here: one bubble
      // cycle separates consecutive frames.
      if (frame_release) begin
        rbank_q       <= ~rbank_q;
        issued_done_q <= 1'b0;
        frames_out    <= frames_out + CNT_WIDTH'(1);
      end
    end
  end

endmodule

// File: tb/tb_fmap_pingpong_buffer.sv
// Self-checking bench for fmap_pingpong_buffer at default parameters.
// A frame-level reference model (queue of accepted beats, counts of captured and
// released frames) predicts i_ready, overflow, frames_out, o_data and o_last.
module tb_fmap_pingpong_buffer;

  localparam int unsigned DATA_WIDTH = 32;
  localparam int unsigned CHANNELS   = 32;
  localparam int unsigned WIDTH      = 7;
  localparam int unsigned CNT_WIDTH  = 16;
  localparam int unsigned BW         = DATA_WIDTH * CHANNELS;
  localparam int unsigned DEPTH      = WIDTH * WIDTH;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [BW-1:0]        i_data;
  logic                 i_valid;
  logic                 i_ready;
  logic [BW-1:0]        o_data;
  logic                 o_valid;
  logic                 o_ready;
  logic                 o_last;
  logic [CNT_WIDTH-1:0] frames_out;
  logic                 overflow;

  always #5 clk = ~clk;

  fmap_pingpong_buffer #(
    .DATA_WIDTH(DATA_WIDTH),
    .CHANNELS  (CHANNELS),
    .WIDTH     (WIDTH),
    .CNT_WIDTH (CNT_WIDTH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .i_data    (i_data),
    .i_valid   (i_valid),
    .i_ready   (i_ready),
    .o_data    (o_data),
    .o_valid   (o_valid),
    .o_ready   (o_ready),
    .o_last    (o_last),
    .frames_out(frames_out),
    .overflow  (overflow)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [BW-1:0] got, input logic [BW-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h required %0h (low 192 bits)", tag, got[191:0], exp[191:0]);
    end
  endtask

  function automatic logic [BW-1:0] rep(input int unsigned v);
    logic [BW-1:0] r;
    for (int c = 0; c < CHANNELS; c++) r[c*DATA_WIDTH +: DATA_WIDTH] = DATA_WIDTH'(v);
    return r;
  endfunction

  function automatic logic [BW-1:0] rnd();
    logic [BW-1:0] r;
    for (int c = 0; c < CHANNELS; c++) r[c*DATA_WIDTH +: DATA_WIDTH] = DATA_WIDTH'($urandom);
    return r;
  endfunction

  // Reference model state, owned by the monitor below.
  logic [BW-1:0] exp_q[$];
  int unsigned   wr_count, rd_count, completed, released;
  bit            ovf_m;
  bit            prev_stall, prev_rel;
  logic [BW-1:0] prev_data;
  logic          prev_last;
  logic [BW-1:0] mon_e;
  bit            mon_rdy, mon_last;
  bit            gap_en = 1'b0;
  int            gaps = 0;

  // Evaluated mid-cycle: compare outputs against the model, then apply the
  // handshakes that the coming rising edge will perform.
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      wr_count = 0; rd_count = 0; completed = 0; released = 0;
      ovf_m = 1'b0; prev_stall = 1'b0; prev_rel = 1'b0;
    end else begin
      // The buffer holds at most two complete frames awaiting release.
      mon_rdy = (completed - released) < 2;
      chk("i_ready", BW'(i_ready), BW'(mon_rdy));
      chk("overflow", BW'(overflow), BW'(ovf_m));
      chk("frames_out", BW'(frames_out), BW'(CNT_WIDTH'(released)));
      if (prev_stall) begin
        chk("stall_valid", BW'(o_valid), BW'(1));
        chk("stall_data", o_data, prev_data);
        chk("stall_last", BW'(o_last), BW'(prev_last));
      end
      if (prev_rel) chk("bubble", BW'(o_valid), BW'(0));
      if (gap_en && !o_valid) gaps++;
      prev_rel = 1'b0;
      if (o_valid && o_ready) begin
        if (exp_q.size() == 0) begin
          chk("spurious_beat", BW'(1), BW'(0));
        end else begin
          chk("frame_complete", BW'(rd_count / DEPTH < completed), BW'(1));
          mon_e = exp_q.pop_front();
          chk("o_data", o_data, mon_e);
          mon_last = (rd_count % DEPTH) == DEPTH - 1;
          chk("o_last", BW'(o_last), BW'(mon_last));
          rd_count++;
          if (mon_last) begin
            released++;
            prev_rel = 1'b1;
          end
        end
      end
      prev_stall = o_valid && !o_ready;
      prev_data  = o_data;
      prev_last  = o_last;
      if (i_valid) begin
        if (mon_rdy) begin
          exp_q.push_back(i_data);
          wr_count++;
          if (wr_count % DEPTH == 0) completed++;
        end else begin
          ovf_m = 1'b1;
        end
      end
    end
  end

  // Offer one beat and hold it until accepted; i_valid is lowered while waiting so
  // no overflow is provoked. Returns 1 time unit after the accepting edge.
  task automatic put(input logic [BW-1:0] d);
    int g = 0;
    i_valid = 1'b0;
    while (!i_ready && g < 5000) begin
      @(posedge clk); #1;
      g++;
    end
    if (g >= 5000) chk("put_timeout", BW'(0), BW'(1));
    i_data  = d;
    i_valid = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic drain();
    int g = 0;
    while ((released != completed || exp_q.size() != 0) && g < 3000) begin
      @(posedge clk); #1;
      g++;
    end
    if (g >= 3000) chk("drain_timeout", BW'(0), BW'(1));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running, required to finish");
    $fatal(1);
  end

  initial begin
    int g0;
    bit drv_done;
    rst = 1'b1; i_valid = 1'b0; i_data = '0; o_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_o_valid", BW'(o_valid), BW'(0));
    chk("rst_o_last", BW'(o_last), BW'(0));
    chk("rst_o_data", o_data, BW'(0));
    chk("rst_frames_out", BW'(frames_out), BW'(0));
    chk("rst_overflow", BW'(overflow), BW'(0));
    chk("rst_i_ready", BW'(i_ready), BW'(1));
    @(posedge clk); #2 rst = 1'b0;
    @(posedge clk); #1;

    // Single frame with o_ready high: first beat one cycle after the 49th write.
    for (int i = 0; i < DEPTH; i++) put(rep(i));
    i_valid = 1'b0;
    chk("lat_before", BW'(o_valid), BW'(0));
    @(posedge clk); #1;
    chk("lat_first_valid", BW'(o_valid), BW'(1));
    chk("lat_first_data", o_data, rep(0));
    drain();
    chk("single_frames_out", BW'(frames_out), BW'(1));

    // Continuous input of four frames: exactly three single-cycle gaps.
    g0 = gaps;
    fork
      begin
        for (int i = 0; i < 4 * DEPTH; i++) put(rnd());
        i_valid = 1'b0;
      end
      begin
        int g = 0;
        while (!o_valid && g < 1000) begin @(posedge clk); #1; g++; end
        gap_en = 1'b1;
        while (released != 5 && g < 3000) begin @(posedge clk); #1; g++; end
        gap_en = 1'b0;
        if (g >= 3000) chk("overlap_timeout", BW'(0), BW'(1));
      end
    join
    chk("overlap_gaps", BW'(gaps - g0), BW'(3));
    chk("overlap_frames_out", BW'(frames_out), BW'(5));
    chk("overlap_overflow", BW'(overflow), BW'(0));

    // Random output backpressure with gappy input over two frames.
    drv_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 2 * DEPTH; i++) begin
          if ($urandom_range(0, 3) == 0) begin
            i_valid = 1'b0;
            @(posedge clk); #1;
          end
          put(rnd());
        end
        i_valid  = 1'b0;
        drv_done = 1'b1;
      end
      begin
        int g = 0;
        while ((!drv_done || released != completed) && g < 5000) begin
          o_ready = 1'($urandom_range(0, 1));
          @(posedge clk); #1;
          g++;
        end
        if (g >= 5000) chk("bp_timeout", BW'(0), BW'(1));
        o_ready = 1'b1;
      end
    join
    drain();
    chk("bp_frames_out", BW'(frames_out), BW'(7));

    // Both banks fill with the output stalled; extra beats are dropped.
    o_ready = 1'b0;
    for (int i = 0; i < 2 * DEPTH; i++) put(rnd());
    i_valid = 1'b0;
    chk("both_full_i_ready", BW'(i_ready), BW'(0));
    for (int i = 0; i < 5; i++) begin
      i_data  = rnd();
      i_valid = 1'b1;
      @(posedge clk); #1;
    end
    i_valid = 1'b0;
    chk("overflow_set", BW'(overflow), BW'(1));
    o_ready = 1'b1;
    drain();
    chk("ovf_frames_out", BW'(frames_out), BW'(9));
    chk("overflow_sticky", BW'(overflow), BW'(1));

    // Reset in the middle of frame 1 capture while frame 0 replays.
    for (int i = 0; i < DEPTH + 20; i++) put(rnd());
    i_valid = 1'b0;
    chk("pre_reset_valid", BW'(o_valid), BW'(1));
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_o_valid", BW'(o_valid), BW'(0));
    chk("mid_rst_o_last", BW'(o_last), BW'(0));
    chk("mid_rst_o_data", o_data, BW'(0));
    chk("mid_rst_frames_out", BW'(frames_out), BW'(0));
    chk("mid_rst_overflow", BW'(overflow), BW'(0));
    chk("mid_rst_i_ready", BW'(i_ready), BW'(1));
    @(posedge clk); #2 rst = 1'b0;
    @(posedge clk); #1;
    for (int i = 0; i < DEPTH; i++) put(rnd());
    i_valid = 1'b0;
    drain();
    chk("post_rst_frames_out", BW'(frames_out), BW'(1));
    chk("post_rst_overflow", BW'(overflow), BW'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
